// File: rtl/bsg_manycore_pkt_decode_lock_pkg.sv
// Shared definitions for the registered manycore packet decoder:
// op encodings, lock/config field constants and the packet width helper.
package bsg_manycore_pkt_decode_lock_pkg;

    localparam int op_width_gp = 2;

    typedef enum logic [op_width_gp-1:0] {
        e_op_load   = 2'd0,
        e_op_store  = 2'd1,
        e_op_config = 2'd2,
        e_op_lock   = 2'd3
    } bsg_manycore_packet_op_e;

    // Payload bit of a lock packet: 1 = acquire, 0 = release
    localparam int lock_acquire_bit_gp = 0;

    // Config address that writes the freeze bit, and the payload bit it takes
    localparam int config_freeze_addr_gp = 0;
    localparam int config_freeze_bit_gp  = 0;

    // Packet layout, MSB first:
    //   addr | op | op_ex (byte mask) | payload | src_y | src_x | dst_y | dst_x
    function automatic int bsg_manycore_packet_width(input int addr_w, input int data_w,
                                                     input int x_w, input int y_w);
        return addr_w + op_width_gp + (data_w / 8) + data_w + 2 * x_w + 2 * y_w;
    endfunction

endpackage

// File: rtl/bsg_manycore_lock_ctrl.sv
// Endpoint lock: two-state FSM plus the (x,y) of the holder. Flags requests
// from non-holders while locked and releases that do not come from the holder.
module bsg_manycore_lock_ctrl #(
    parameter int x_cord_width_p = 2,
    parameter int y_cord_width_p = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      acquire_i,
    input  logic                      release_i,
    input  logic [x_cord_width_p-1:0] req_x_i,
    input  logic [y_cord_width_p-1:0] req_y_i,
    output logic                      lock_o,
    output logic [x_cord_width_p-1:0] lock_x_o,
    output logic [y_cord_width_p-1:0] lock_y_o,
    output logic                      block_o,
    output logic                      illegal_o
);

    typedef enum logic {
        e_unlocked = 1'b0,
        e_locked   = 1'b1
    } lock_state_e;

    lock_state_e               state_q, state_d;
    logic [x_cord_width_p-1:0] holder_x_q, holder_x_d;
    logic [y_cord_width_p-1:0] holder_y_q, holder_y_d;
    logic                      is_holder;

    assign is_holder = (req_x_i == holder_x_q) && (req_y_i == holder_y_q);

    // Next lock state: acquire latches the requester, only the holder may release
    always_comb begin
        state_d    = state_q;
        holder_x_d = holder_x_q;
        holder_y_d = holder_y_q;
        case (state_q)
            e_unlocked: begin
                if (acquire_i) begin
                    state_d    = e_locked;
                    holder_x_d = req_x_i;
                    holder_y_d = req_y_i;
                end
            end
            e_locked: begin
                if (release_i && is_holder) begin
                    state_d = e_unlocked;
                end
            end
            default: state_d = e_unlocked;
        endcase
    end

    // Lock state and holder registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_unlocked;
            holder_x_q <= '0;
            holder_y_q <= '0;
        end else begin
            state_q    <= state_d;
            holder_x_q <= holder_x_d;
            holder_y_q <= holder_y_d;
        end
    end

    assign lock_o    = (state_q == e_locked);
    assign lock_x_o  = holder_x_q;
    assign lock_y_o  = holder_y_q;
    assign block_o   = lock_o && !is_holder;
    assign illegal_o = release_i && (!lock_o || !is_holder);

endmodule

// File: rtl/bsg_manycore_pkt_decode_lock.sv
// Registered manycore packet decoder. Consumes config and lock packets
// internally and forwards load/store requests through a one-entry output
// register with full-throughput valid/yumi handshaking.
module bsg_manycore_pkt_decode_lock
    import bsg_manycore_pkt_decode_lock_pkg::*;
#(
    parameter int x_cord_width_p  = 2,
    parameter int y_cord_width_p  = 2,
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 8,
    parameter bit freeze_init_p   = 1'b1,
    parameter int err_cnt_width_p = 8,
    localparam int packet_width_lp = bsg_manycore_packet_width(addr_width_p, data_width_p,
                                                               x_cord_width_p, y_cord_width_p),
    localparam int mask_width_lp = data_width_p / 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [packet_width_lp-1:0] data_i,
    output logic                       ready_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic                       we_o,
    output logic [addr_width_p-1:0]    addr_o,
    output logic [data_width_p-1:0]    data_o,
    output logic [mask_width_lp-1:0]   mask_o,
    output logic [x_cord_width_p-1:0]  from_x_cord_o,
    output logic [y_cord_width_p-1:0]  from_y_cord_o,
    output logic                       freeze_o,
    output logic                       lock_o,
    output logic [x_cord_width_p-1:0]  lock_x_o,
    output logic [y_cord_width_p-1:0]  lock_y_o,
    output logic                       error_o,
    output logic [err_cnt_width_p-1:0] error_cnt_o
);

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        bsg_manycore_packet_op_e   op;
        logic [mask_width_lp-1:0]  op_ex;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y_cord;
        logic [x_cord_width_p-1:0] src_x_cord;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } bsg_manycore_packet_s;

    bsg_manycore_packet_s pkt;
    assign pkt = data_i;

    logic ready_l, accept;
    logic is_ldst, is_cfg, is_lock, is_undef;
    logic lock_acq_bit, cfg_addr_ok;
    logic acquire_s, release_s;
    logic lock_block, lock_illegal;

    logic                       v_q, v_d;
    logic                       we_q, we_d;
    logic [addr_width_p-1:0]    addr_q, addr_d;
    logic [data_width_p-1:0]    data_q, data_d;
    logic [mask_width_lp-1:0]   mask_q, mask_d;
    logic [x_cord_width_p-1:0]  from_x_q, from_x_d;
    logic [y_cord_width_p-1:0]  from_y_q, from_y_d;
    logic                       freeze_q, freeze_d;
    logic                       error_q, error_d;
    logic [err_cnt_width_p-1:0] error_cnt_q, error_cnt_d;

    assign lock_acq_bit = pkt.payload[lock_acquire_bit_gp];
    assign cfg_addr_ok  = (pkt.addr == addr_width_p'(config_freeze_addr_gp));

    // Op decode and acceptance; only loads/stores wait on the output register
    always_comb begin
        ready_l  = 1'b0;
        is_ldst  = 1'b0;
        is_cfg   = 1'b0;
        is_lock  = 1'b0;
        is_undef = 1'b0;
        case (pkt.op)
            e_op_load, e_op_store: begin
                is_ldst = 1'b1;
                ready_l = !lock_block && (!v_q || yumi_i);
            end
            e_op_config: begin
                is_cfg  = 1'b1;
                ready_l = 1'b1;
            end
            e_op_lock: begin
                is_lock = 1'b1;
                // Releases are never held off so a bad release can be flagged
                ready_l = lock_acq_bit ? !lock_block : 1'b1;
            end
            default: begin
                is_undef = 1'b1;
                ready_l  = 1'b1;
            end
        endcase
    end

    assign ready_o   = ready_l;
    assign accept    = v_i && ready_l;
    assign acquire_s = accept && is_lock && lock_acq_bit;
    assign release_s = accept && is_lock && !lock_acq_bit;

    bsg_manycore_lock_ctrl #(
        .x_cord_width_p(x_cord_width_p),
        .y_cord_width_p(y_cord_width_p)
    ) lock_ctrl (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .acquire_i(acquire_s),
        .release_i(release_s),
        .req_x_i  (pkt.src_x_cord),
        .req_y_i  (pkt.src_y_cord),
        .lock_o   (lock_o),
        .lock_x_o (lock_x_o),
        .lock_y_o (lock_y_o),
        .block_o  (lock_block),
        .illegal_o(lock_illegal)
    );

    // Next state of the request register, freeze bit and error tracking
    always_comb begin
        v_d         = v_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        from_x_d    = from_x_q;
        from_y_d    = from_y_q;
        freeze_d    = freeze_q;
        error_d     = 1'b0;
        error_cnt_d = error_cnt_q;

        if (accept && is_ldst) begin
            v_d      = 1'b1;
            we_d     = (pkt.op == e_op_store);
            addr_d   = pkt.addr;
            data_d   = pkt.payload;
            mask_d   = (pkt.op == e_op_store) ? pkt.op_ex : '1;
            from_x_d = pkt.src_x_cord;
            from_y_d = pkt.src_y_cord;
        end else if (yumi_i) begin
            v_d = 1'b0;
        end

        if (accept && is_cfg && cfg_addr_ok) begin
            freeze_d = pkt.payload[config_freeze_bit_gp];
        end

        error_d = accept && (is_undef || (is_cfg && !cfg_addr_ok) || lock_illegal);
        if (error_d && !(&error_cnt_q)) begin
            error_cnt_d = error_cnt_q + 1'b1;
        end
    end

    // Control state with reset; request payload has no reset and loads only on accept
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q         <= 1'b0;
            freeze_q    <= freeze_init_p;
            error_q     <= 1'b0;
            error_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            freeze_q    <= freeze_d;
            error_q     <= error_d;
            error_cnt_q <= error_cnt_d;
        end
        we_q     <= we_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        mask_q   <= mask_d;
        from_x_q <= from_x_d;
        from_y_q <= from_y_d;
    end

    assign v_o           = v_q;
    assign we_o          = we_q;
    assign addr_o        = addr_q;
    assign data_o        = data_q;
    assign mask_o        = mask_q;
    assign from_x_cord_o = from_x_q;
    assign from_y_cord_o = from_y_q;
    assign freeze_o      = freeze_q;
    assign error_o       = error_q;
    assign error_cnt_o   = error_cnt_q;

endmodule

// File: tb/tb_bsg_manycore_pkt_decode_lock.sv
// Testbench for bsg_manycore_pkt_decode_lock: directed scenarios followed by
// random traffic, all checked against a rule-level reference model.
module tb_bsg_manycore_pkt_decode_lock;
    import bsg_manycore_pkt_decode_lock_pkg::*;

    localparam int XW = 2;
    localparam int YW = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int EW = 3;
    localparam bit FI = 1'b1;
    localparam int MW = DW / 8;
    localparam int PW = bsg_manycore_packet_width(AW, DW, XW, YW);

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          v_i = 1'b0;
    logic [PW-1:0] data_i = '0;
    logic          ready_o;
    logic          v_o;
    logic          yumi_i = 1'b0;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic [MW-1:0] mask_o;
    logic [XW-1:0] from_x_cord_o;
    logic [YW-1:0] from_y_cord_o;
    logic          freeze_o;
    logic          lock_o;
    logic [XW-1:0] lock_x_o;
    logic [YW-1:0] lock_y_o;
    logic          error_o;
    logic [EW-1:0] error_cnt_o;

    bsg_manycore_pkt_decode_lock #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .freeze_init_p(FI), .err_cnt_width_p(EW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .yumi_i(yumi_i), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .mask_o(mask_o), .from_x_cord_o(from_x_cord_o), .from_y_cord_o(from_y_cord_o),
        .freeze_o(freeze_o), .lock_o(lock_o), .lock_x_o(lock_x_o), .lock_y_o(lock_y_o),
        .error_o(error_o), .error_cnt_o(error_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_v, m_we, m_freeze, m_locked, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    logic [XW-1:0] m_fx, m_hx;
    logic [YW-1:0] m_fy, m_hy;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [1:0] op, input logic [MW-1:0] opex,
                                         input logic [AW-1:0] addr, input logic [DW-1:0] d,
                                         input logic [XW-1:0] sx, input logic [YW-1:0] sy);
        return {addr, op, opex, d, sy, sx, YW'(0), XW'(0)};
    endfunction

    task automatic check_outputs();
        chk("v_o", 64'(v_o), 64'(m_v));
        chk("freeze_o", 64'(freeze_o), 64'(m_freeze));
        chk("lock_o", 64'(lock_o), 64'(m_locked));
        chk("error_o", 64'(error_o), 64'(m_err));
        chk("error_cnt_o", 64'(error_cnt_o), 64'(m_cnt));
        if (m_locked) begin
            chk("lock_x_o", 64'(lock_x_o), 64'(m_hx));
            chk("lock_y_o", 64'(lock_y_o), 64'(m_hy));
        end
        if (m_v) begin
            chk("we_o", 64'(we_o), 64'(m_we));
            chk("addr_o", 64'(addr_o), 64'(m_addr));
            chk("data_o", 64'(data_o), 64'(m_data));
            chk("mask_o", 64'(mask_o), 64'(m_mask));
            chk("from_x", 64'(from_x_cord_o), 64'(m_fx));
            chk("from_y", 64'(from_y_cord_o), 64'(m_fy));
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        m_v = 0; m_freeze = FI; m_locked = 0; m_hx = '0; m_hy = '0; m_err = 0; m_cnt = 0;
        check_outputs();
        chk("reset_lock_x", 64'(lock_x_o), 64'(0));
        chk("reset_lock_y", 64'(lock_y_o), 64'(0));
    endtask

    // One clock: drive inputs, check ready_o, advance the model, check registered outputs
    task automatic step(input bit v, input logic [PW-1:0] pkt, input bit y);
        logic [AW-1:0] f_addr;
        logic [1:0]    f_op;
        logic [MW-1:0] f_opex;
        logic [DW-1:0] f_data;
        logic [XW-1:0] f_sx, f_dx;
        logic [YW-1:0] f_sy, f_dy;
        bit blk, rdy, acc, is_holder, bad;
        {f_addr, f_op, f_opex, f_data, f_sy, f_sx, f_dy, f_dx} = pkt;
        v_i = v; data_i = pkt; yumi_i = y;
        #1;
        is_holder = (f_sx == m_hx) && (f_sy == m_hy);
        blk = m_locked && !is_holder;
        case (f_op)
            2'd0, 2'd1: rdy = !blk && (!m_v || y);
            2'd2:       rdy = 1'b1;
            default:    rdy = f_data[0] ? !blk : 1'b1;
        endcase
        if (v) chk("ready_o", 64'(ready_o), 64'(rdy));
        acc = v && rdy;
        bad = 0;
        @(posedge clk);
        if (acc && f_op <= 2'd1) begin
            m_v = 1; m_we = (f_op == 2'd1); m_addr = f_addr; m_data = f_data;
            m_mask = (f_op == 2'd1) ? f_opex : '1; m_fx = f_sx; m_fy = f_sy;
        end else if (y) begin
            m_v = 0;
        end
        if (acc && f_op == 2'd2) begin
            if (f_addr == 0) m_freeze = f_data[0];
            else bad = 1;
        end
        if (acc && f_op == 2'd3) begin
            if (f_data[0]) begin
                if (!m_locked) begin m_locked = 1; m_hx = f_sx; m_hy = f_sy; end
            end else if (m_locked && is_holder) begin
                m_locked = 0;
            end else begin
                bad = 1;
            end
        end
        m_err = bad;
        if (bad && m_cnt < (1 << EW) - 1) m_cnt++;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single store, then drain
        step(1, mk(2'd1, 4'hF, 8'h10, 32'hDEADBEEF, 2'd1, 2'd2), 0);
        chk("st_v", 64'(v_o), 64'(1));
        chk("st_we", 64'(we_o), 64'(1));
        chk("st_addr", 64'(addr_o), 64'h10);
        chk("st_mask", 64'(mask_o), 64'hF);
        chk("st_data", 64'(data_o), 64'hDEADBEEF);
        step(0, '0, 1);
        chk("drain_v", 64'(v_o), 64'(0));

        // Back-to-back stores with consumer always taking
        for (int i = 0; i < 4; i++) begin
            step(1, mk(2'd1, 4'h3, AW'(8'h20 + i), DW'(32'h100 + i), 2'd0, 2'd1), m_v);
            chk("b2b_data", 64'(data_o), 64'(32'h100 + i));
        end
        step(0, '0, 1);

        // Freeze config, then a bad config address
        step(1, mk(2'd2, 4'h0, 8'h00, 32'h0, 2'd0, 2'd0), 0);
        chk("freeze0", 64'(freeze_o), 64'(0));
        step(1, mk(2'd2, 4'h0, 8'h00, 32'h1, 2'd0, 2'd0), 0);
        chk("freeze1", 64'(freeze_o), 64'(1));
        step(1, mk(2'd2, 4'h0, 8'h04, 32'h0, 2'd0, 2'd0), 0);
        chk("cfg_err", 64'(error_o), 64'(1));
        chk("cfg_err_cnt", 64'(error_cnt_o), 64'(1));
        step(0, '0, 0);
        chk("err_pulse_end", 64'(error_o), 64'(0));

        // Lock blocking a foreign store until the holder releases
        step(1, mk(2'd3, 4'h0, 8'h00, 32'h1, 2'd1, 2'd1), 0);
        chk("acq_lock", 64'(lock_o), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step(1, mk(2'd1, 4'hF, 8'h30, 32'hA5A5A5A5, 2'd2, 2'd0), 0);
            chk("blocked_v", 64'(v_o), 64'(0));
        end
        step(1, mk(2'd3, 4'h0, 8'h00, 32'h0, 2'd1, 2'd1), 0);
        chk("rel_lock", 64'(lock_o), 64'(0));
        step(1, mk(2'd1, 4'hF, 8'h30, 32'hA5A5A5A5, 2'd2, 2'd0), 0);
        chk("unblocked_v", 64'(v_o), 64'(1));
        step(0, '0, 1);

        // Release by a non-holder, then reset while locked
        step(1, mk(2'd3, 4'h0, 8'h00, 32'h1, 2'd1, 2'd1), 0);
        step(1, mk(2'd3, 4'h0, 8'h00, 32'h0, 2'd3, 2'd3), 0);
        chk("bad_rel_err", 64'(error_o), 64'(1));
        chk("bad_rel_lock", 64'(lock_o), 64'(1));
        chk("bad_rel_hx", 64'(lock_x_o), 64'(1));
        chk("bad_rel_hy", 64'(lock_y_o), 64'(1));
        do_reset();
        chk("rst_lock", 64'(lock_o), 64'(0));
        chk("rst_freeze", 64'(freeze_o), 64'(FI));

        // Stalled output: load held off, config still accepted
        step(1, mk(2'd0, 4'h0, 8'h40, 32'h12345678, 2'd2, 2'd3), 0);
        chk("ld_mask", 64'(mask_o), 64'hF);
        chk("ld_we", 64'(we_o), 64'(0));
        step(1, mk(2'd0, 4'h0, 8'h44, 32'h0, 2'd2, 2'd3), 0);
        chk("stall_addr", 64'(addr_o), 64'h40);
        step(1, mk(2'd2, 4'h0, 8'h00, 32'h0, 2'd0, 2'd0), 0);
        chk("stall_cfg", 64'(freeze_o), 64'(0));
        step(0, '0, 1);

        // Error counter saturation
        for (int i = 0; i < 9; i++) step(1, mk(2'd2, 4'h0, 8'h08, 32'h0, 2'd0, 2'd0), 0);
        chk("err_sat", 64'(error_cnt_o), 64'(7));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] op;
            logic [AW-1:0] a;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) == 0) ? AW'(0) : AW'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0),
                     mk(op, MW'($urandom), a, DW'($urandom),
                        XW'($urandom_range(0, 1)), YW'($urandom_range(0, 1))),
                     m_v && ($urandom_range(0, 2) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_pkt_decode_lock.md
Name: bsg_manycore_pkt_decode_lock

Overview:
- Registered successor to the combinational manycore packet decoder.
- Accepts network packets over a valid/ready handshake and decodes four ops: load, masked store, freeze config, lock acquire/release.
- Holds the tile freeze state and an endpoint lock owned by one (x,y) source.
- Forwards only load/store requests to the memory side through a one-entry output register; sits between the endpoint FIFO and the tile memory/DMEM arbiter.

Parameters:
- x_cord_width_p, "inv", x-coordinate width.
- y_cord_width_p, "inv", y-coordinate width.
- data_width_p, "inv", payload width; multiple of 8.
- addr_width_p, "inv", word address width.
- freeze_init_p, 1, freeze_o value after reset.
- err_cnt_width_p, 8, width of the saturating error counter.
- packet_width_lp, derived, `bsg_manycore_packet_width(addr,data,x,y)`.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  input packet valid.
- data_i  in  packet_width_lp  packet (bsg_manycore_packet_s).
- ready_o  out  1  packet accepted when v_i & ready_o.
- v_o  out  1  decoded load/store request valid.
- yumi_i  in  1  consumer takes request; legal only when v_o=1.
- we_o  out  1  1=store, 0=load.
- addr_o  out  addr_width_p  request address.
- data_o  out  data_width_p  store data (loads: packet data, don't-care).
- mask_o  out  data_width_p/8  byte mask; all-ones for loads.
- from_x_cord_o  out  x_cord_width_p  requester x.
- from_y_cord_o  out  y_cord_width_p  requester y.
- freeze_o  out  1  tile freeze state.
- lock_o  out  1  endpoint locked.
- lock_x_o  out  x_cord_width_p  lock holder x.
- lock_y_o  out  y_cord_width_p  lock holder y.
- error_o  out  1  one-cycle pulse on a malformed or illegal packet.
- error_cnt_o  out  err_cnt_width_p  saturating count of errors.

Behaviour:
- Op encoding: 0 load, 1 store (op_ex = byte mask), 2 config, 3 lock (data[0]: 1 = acquire, 0 = release).
- Reset values (sync): v_o=0, freeze_o=freeze_init_p, lock_o=0, lock_x_o/lock_y_o=0, error_o=0, error_cnt_o=0. Reset mid-lock or with v_o=1 drops both the lock and the pending request.
- Lock FSM has two states:
  - UNLOCKED --acquire accepted--> LOCKED; holder is latched from from_x/from_y.
  - LOCKED --release from holder--> UNLOCKED.
  - Acquire by the current holder: no state change, no error.
  - Release by a non-holder or while UNLOCKED: error, no state change.
- Blocking: in LOCKED, a load/store/acquire from a non-holder is held off with ready_o=0 until release. Config packets are never blocked.
- Acceptance: ready_o=1 when
  - the op is config or lock and not blocked; or
  - the op is load/store, not blocked, and (~v_o | yumi_i).
- ready_o depends combinationally on data_i; it is evaluated only when v_i=1.
- Latency: an accepted load/store appears on v_o and the payload outputs the next cycle. Outputs hold stable while v_o & ~yumi_i.
- Full throughput: accepting and yumi in the same cycle keeps v_o=1 with the new payload. yumi without accept clears v_o.
- Config (op 2):
  - addr==0: freeze_o <= data[0] on the cycle after acceptance.
  - addr!=0: error.
  - Config is never forwarded to the output.
- Lock ops are consumed internally, never forwarded. Lock state changes the cycle after acceptance.
- Undefined op: impossible with a 2-bit op. If the package widens op, any unlisted value is accepted, dropped, and flagged as an error.
- error_o pulses for one cycle after an accepted erroneous packet. error_cnt_o increments and saturates at all-ones.
- Loads and stores are forwarded regardless of freeze_o; freeze affects only the core.
- The registered request fields are written only on accept, which saves power.

Decomposition:
- Shared package/header (bsg_manycore_packet.vh): op encodings (e_op_load, e_op_store, e_op_config, e_op_lock), lock sub-op bit index, config freeze address constant, bsg_manycore_packet_s.
- Sub-module: bsg_manycore_lock_ctrl. It holds the FSM and holder registers, takes acquire/release strobes plus the requester coordinates, and outputs lock_o, holder, block, and illegal.

Test Plan:
- Reset, then store from (1,2), addr 0x10, data 0xDEADBEEF, mask 0xF → next cycle v_o=1, we_o=1, addr_o=0x10, mask_o=0xF; yumi → v_o=0.
- Back-to-back 4 stores with yumi_i tied 1 → ready_o=1 every cycle, v_o=1 for 4 consecutive cycles, data in order.
- Config addr 0 data 0, then data 1 → freeze_o goes 0 then 1, one cycle after each accept; v_o stays 0. Config addr 4 → error_o pulse, error_cnt_o=1.
- Acquire from (1,1); store from (2,0) → ready_o=0 held. Release from (1,1) → store accepted the cycle after release, lock_o=0.
- Release from (3,3) while held by (1,1) → error_o=1, lock_o stays 1, holder (1,1). Assert reset → lock_o=0, freeze_o=freeze_init_p.
- Hold yumi_i=0 with v_o=1, then offer a load → ready_o=0. Offer config in the same state → accepted.
